traffic_conflict_monitor: RTL

- Independent safety monitor on the receiving end of the highway/country light bus.
- Samples the controller's one-hot light codes every clock and checks encoding, mutual exclusion, per-light sequence, yellow dwell and all-red clearance.
- Drives the physical lamp outputs: a registered copy of the commanded lights while healthy, a latched flashing all-red on any violation.
- Also raises a non-fatal warning when the country green is held excessively long (stuck sensor).

---
 rtl/traffic_conflict_monitor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the highway/country light bus: validates the commanded one-hot
// light codes every clock, drives the lamps, and latches a flashing all-red on any violation.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW     = 1,
    parameter int MIN_ALLRED_H2C = 1,
    parameter int MIN_ALLRED_C2H = 0,
    parameter int FLASH_HALF     = 4,
    parameter int CNTRY_MAX      = 16,
    parameter int CW             = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [2:0] hwy,
    input  logic [2:0] cntry,
    output logic [2:0] lamp_hwy,
    output logic [2:0] lamp_cntry,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       cntry_long
);

    localparam logic [2:0]    RED        = 3'b100;
    localparam logic [2:0]    YEL        = 3'b010;
    localparam logic [2:0]    GRN        = 3'b001;
    localparam logic [CW-1:0] CNT_SAT    = '1;
    localparam logic [CW-1:0] FLASH_LAST = CW'(2 * FLASH_HALF - 1);

    typedef enum logic [1:0] {ARM, RUN, FLT} state_t;

    state_t        state;
    logic [2:0]    prev_hwy, prev_cntry;
    logic [CW-1:0] yel_h, yel_c, allred, cgreen, flash_cnt;
    logic [CW-1:0] yel_h_nxt, yel_c_nxt, allred_nxt, cgreen_nxt, flash_nxt;
    logic [2:0]    viol_code;
    logic          full_checks;

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    // NOTE: every variable assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        full_checks = (state == RUN);
        viol_code   = 3'd0;
        yel_h_nxt   = (hwy == YEL) ? sat_inc(yel_h) : '0;
        yel_c_nxt   = (cntry == YEL) ? sat_inc(yel_c) : '0;
        allred_nxt  = (hwy == RED && cntry == RED) ? sat_inc(allred) : '0;
        cgreen_nxt  = (cntry == GRN) ? sat_inc(cgreen) : '0;
        flash_nxt   = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;

        // Priority chain: the lowest-numbered violation wins.
        if (!one_hot3(hwy) || !one_hot3(cntry))
            viol_code = 3'd1;
        else if (hwy != RED && cntry != RED)
            viol_code = 3'd2;
        else if (full_checks && !legal_step(prev_hwy, hwy))
            viol_code = 3'd3;
        else if (full_checks && !legal_step(prev_cntry, cntry))
            viol_code = 3'd4;
        else if (full_checks &&
                 ((prev_hwy == YEL && hwy != YEL && int'(yel_h) < MIN_YELLOW) ||
                  (prev_cntry == YEL && cntry != YEL && int'(yel_c) < MIN_YELLOW)))
            viol_code = 3'd5;
        else if (full_checks &&
                 ((prev_cntry == RED && cntry == GRN && int'(allred) < MIN_ALLRED_H2C) ||
                  (prev_hwy == RED && hwy == GRN && int'(allred) < MIN_ALLRED_C2H)))
            viol_code = 3'd6;
    end

    // NOTE: sequential state uses non-blocking assignments only; clear wins over every other branch.
    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= ARM;
            prev_hwy   <= RED;
            prev_cntry <= RED;
            yel_h      <= '0;
            yel_c      <= '0;
            allred     <= '0;
            cgreen     <= '0;
            flash_cnt  <= '0;
            lamp_hwy   <= RED;
            lamp_cntry <= RED;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            cntry_long <= 1'b0;
        end else begin
            case (state)
                ARM, RUN: begin
                    if (viol_code != 3'd0) begin
                        // Violating command never reaches the lamps: flash starts on the RED phase.
                        state      <= FLT;
                        fault      <= 1'b1;
                        fault_code <= viol_code;
                        flash_cnt  <= '0;
                        lamp_hwy   <= RED;
                        lamp_cntry <= RED;
                        cntry_long <= 1'b0;
                    end else begin
                        state      <= RUN;
                        prev_hwy   <= hwy;
                        prev_cntry <= cntry;
                        yel_h      <= yel_h_nxt;
                        yel_c      <= yel_c_nxt;
                        allred     <= allred_nxt;
                        cgreen     <= cgreen_nxt;
                        lamp_hwy   <= hwy;
                        lamp_cntry <= cntry;
                        cntry_long <= int'(cgreen_nxt) >= CNTRY_MAX;
                    end
                end
                default: begin
                    state      <= FLT;
                    flash_cnt  <= flash_nxt;
                    lamp_hwy   <= (int'(flash_nxt) < FLASH_HALF) ? RED : 3'b000;
                    lamp_cntry <= (int'(flash_nxt) < FLASH_HALF) ? RED : 3'b000;
                    cntry_long <= 1'b0;
                end
            endcase
        end
    end

endmodule
